// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU-with-memory top level: default bus widths
// and the identifiers of the two ports that share the block RAM.
package cpu_mem_pkg;

    localparam int CPU_ADDR_W = 16;
    localparam int CPU_DATA_W = 16;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_AUX = 1'b1
    } port_id_t;

endpackage

// File: rtl/mem_arb_wait_counter.sv
// Starvation counter for the low-priority port. It counts consecutive cycles
// in which the port requested but lost. at_max tells the grant logic that the
// port must win the next decision.
module mem_arb_wait_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic req,
    input  logic gnt,
    output logic at_max
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;

    // Count lost request cycles, restart on a grant or a dropped request, hold at the limit
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wait_cnt <= '0;
        end else if (!req || gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != MAX_CNT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign at_max = (wait_cnt == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single-port synchronous-read block RAM.
// Port 0 (CPU) has fixed priority; port 1 (aux master) is forced through once
// it has lost MAX_WAIT consecutive cycles. Read data is steered back to the
// port that issued the read using a one-entry return tag.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int DATA_W   = CPU_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic              at_max;
    logic              rd_pend;
    port_id_t          rd_id;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    mem_arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .Clock  (Clock),
        .Reset  (Reset),
        .req    (req1),
        .gnt    (gnt1),
        .at_max (at_max)
    );

    // Grant decision: starved port 1 first, then port 0, then port 1; nothing during reset
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!Reset) begin
            if (req1 && at_max) begin
                gnt1 = 1'b1;
            end else if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign ram_en = gnt0 | gnt1;

    // RAM command mux: granted port's qualifiers, all zero when idle
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt0) begin
            ram_we    = we0;
            ram_addr  = addr0;
            ram_wdata = wdata0;
        end else if (gnt1) begin
            ram_we    = we1;
            ram_addr  = addr1;
            ram_wdata = wdata1;
        end
    end

    // Read-return tag: remembers that the RAM will present data next cycle and for whom
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rd_pend <= 1'b0;
            rd_id   <= PORT_CPU;
        end else begin
            rd_pend <= ram_en & ~ram_we;
            if (ram_en && !ram_we) begin
                rd_id <= gnt1 ? PORT_AUX : PORT_CPU;
            end
        end
    end

    // A tag left over from the cycle before reset must not escape as a pulse
    assign rvalid0 = rd_pend && (rd_id == PORT_CPU) && !Reset;
    assign rvalid1 = rd_pend && (rd_id == PORT_AUX) && !Reset;

    // Per-port data registers keep the last returned word while the other port is served
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (rvalid0) rdata0_q <= ram_rdata;
            if (rvalid1) rdata1_q <= ram_rdata;
        end
    end

    // The returning word is visible in its valid cycle; otherwise the held value
    assign rdata0 = rvalid0 ? ram_rdata : rdata0_q;
    assign rdata1 = rvalid1 ? ram_rdata : rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a behavioural RAM device, a cycle-level
// reference model compared on every falling edge, a requester-protocol
// checker, and directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MW = 4;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MW)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous-read single-port RAM device
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge Clock) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else        ram_rdata     <= ram[ram_addr];
        end
    end

    // Reference model state
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    int            lost = 0;
    bit            pend = 1'b0;
    int            pend_port = 0;
    logic [DW-1:0] pend_data = '0;
    logic [DW-1:0] hold [2];
    bit            hold_known = 1'b0;

    always @(negedge Clock) begin : model_cmp
        logic          eg0, eg1, ev0, ev1, ewe;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ewd, ed0, ed1;
        eg1   = !Reset && req1 && (lost >= MW || !req0);
        eg0   = !Reset && req0 && !eg1;
        ev0   = !Reset && pend && (pend_port == 0);
        ev1   = !Reset && pend && (pend_port == 1);
        ed0   = ev0 ? pend_data : hold[0];
        ed1   = ev1 ? pend_data : hold[1];
        ewe   = eg0 ? we0    : (eg1 ? we1    : 1'b0);
        eaddr = eg0 ? addr0  : (eg1 ? addr1  : '0);
        ewd   = eg0 ? wdata0 : (eg1 ? wdata1 : '0);
        chk("m_gnt0", gnt0, eg0);
        chk("m_gnt1", gnt1, eg1);
        chk("m_ram_en", ram_en, eg0 | eg1);
        chk("m_ram_we", ram_we, ewe);
        chk("m_ram_addr", ram_addr, eaddr);
        chk("m_ram_wdata", ram_wdata, ewd);
        chk("m_rvalid0", rvalid0, ev0);
        chk("m_rvalid1", rvalid1, ev1);
        if (hold_known || ev0) chk("m_rdata0", rdata0, ed0);
        if (hold_known || ev1) chk("m_rdata1", rdata1, ed1);
        if (Reset) begin
            lost       = 0;
            pend       = 1'b0;
            hold[0]    = '0;
            hold[1]    = '0;
            hold_known = 1'b1;
        end else begin
            if (ev0) hold[0] = pend_data;
            if (ev1) hold[1] = pend_data;
            pend = 1'b0;
            if (eg0 || eg1) begin
                if (ewe) begin
                    shadow[eaddr] = ewd;
                end else begin
                    pend      = 1'b1;
                    pend_port = eg1 ? 1 : 0;
                    pend_data = shadow[eaddr];
                end
            end
            if (req1 && !eg1) lost = (lost < MW) ? lost + 1 : lost;
            else              lost = 0;
        end
    end

    // Requester protocol: qualifiers stay put while a request waits
    logic          w0 = 1'b0, w1 = 1'b0;
    logic [32:0]   q0, q1;
    always @(posedge Clock) begin
        if (w0 && req0) chk("req0_stable", {we0, addr0, wdata0}, q0);
        if (w1 && req1) chk("req1_stable", {we1, addr1, wdata1}, q1);
        w0 = req0 && !gnt0;
        w1 = req1 && !gnt1;
        q0 = {we0, addr0, wdata0};
        q1 = {we1, addr1, wdata1};
    end

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic neg();
        @(negedge Clock);
    endtask

    logic          bw  [5];
    logic [AW-1:0] ba  [5];
    logic [DW-1:0] bd  [5];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]    = DW'(i) ^ 16'h5A5A;
            shadow[i] = DW'(i) ^ 16'h5A5A;
        end
        ram[16'h0010] = 16'hBEEF; shadow[16'h0010] = 16'hBEEF;
        ram[16'h0030] = 16'h1111; shadow[16'h0030] = 16'h1111;
        ram[16'h0031] = 16'h2222; shadow[16'h0031] = 16'h2222;
        ram[16'h0041] = 16'h4141; shadow[16'h0041] = 16'h4141;

        Reset = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0001; wdata0 = '0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0002; wdata1 = '0;

        // Reset with both ports requesting
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("rst_gnt0", gnt0, 1'b0);
            chk("rst_gnt1", gnt1, 1'b0);
            chk("rst_ram_en", ram_en, 1'b0);
            chk("rst_rvalid0", rvalid0, 1'b0);
            chk("rst_rvalid1", rvalid1, 1'b0);
            chk("rst_rdata0", rdata0, 16'h0000);
            chk("rst_rdata1", rdata1, 16'h0000);
        end
        cyc();
        Reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        cyc();

        // Single port 0 read
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
        neg();
        chk("rd0_gnt0", gnt0, 1'b1);
        chk("rd0_addr", ram_addr, 16'h0010);
        cyc();
        req0 = 1'b0;
        neg();
        chk("rd0_rvalid0", rvalid0, 1'b1);
        chk("rd0_rdata0", rdata0, 16'hBEEF);
        chk("rd0_rvalid1", rvalid1, 1'b0);
        cyc();
        neg();
        chk("rd0_pulse", rvalid0, 1'b0);
        chk("rd0_hold", rdata0, 16'hBEEF);

        // Port 1 write then read back
        cyc();
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0020; wdata1 = 16'h1234;
        neg();
        chk("wr1_gnt1", gnt1, 1'b1);
        chk("wr1_we", ram_we, 1'b1);
        cyc();
        we1 = 1'b0;
        neg();
        chk("rb1_gnt1", gnt1, 1'b1);
        chk("rb1_we", ram_we, 1'b0);
        cyc();
        req1 = 1'b0;
        neg();
        chk("rb1_rvalid1", rvalid1, 1'b1);
        chk("rb1_rdata1", rdata1, 16'h1234);
        chk("rb1_rvalid0", rvalid0, 1'b0);

        // Starvation bound under continuous port 0 traffic
        cyc();
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0041;
        for (int c = 0; c < 6; c++) begin
            neg();
            chk("stv_gnt0", gnt0, c != 4);
            chk("stv_gnt1", gnt1, c == 4);
            if (c == 5) chk("stv_rdata1", rdata1, 16'h4141);
            cyc();
        end
        req0 = 1'b0; req1 = 1'b0;

        // Interleaved reads, no cross-steering
        cyc();
        req0 = 1'b1; addr0 = 16'h0030;
        req1 = 1'b1; addr1 = 16'h0031;
        neg();
        chk("il_gnt0", gnt0, 1'b1);
        chk("il_gnt1_wait", gnt1, 1'b0);
        cyc();
        req0 = 1'b0;
        neg();
        chk("il_gnt1", gnt1, 1'b1);
        chk("il_rvalid0", rvalid0, 1'b1);
        chk("il_rdata0", rdata0, 16'h1111);
        chk("il_rvalid1_lo", rvalid1, 1'b0);
        cyc();
        req1 = 1'b0;
        neg();
        chk("il_rvalid1", rvalid1, 1'b1);
        chk("il_rdata1", rdata1, 16'h2222);
        chk("il_rvalid0_lo", rvalid0, 1'b0);
        chk("il_rdata0_hold", rdata0, 16'h1111);

        // Reset right after a read grant, with port 1 already waiting
        cyc();
        req0 = 1'b1; addr0 = 16'h0010;
        req1 = 1'b1; addr1 = 16'h0041;
        neg();
        chk("mr_gnt0", gnt0, 1'b1);
        cyc();
        req0 = 1'b0; Reset = 1'b1;
        neg();
        chk("mr_rvalid0_rst", rvalid0, 1'b0);
        chk("mr_gnt1_rst", gnt1, 1'b0);
        cyc();
        Reset = 1'b0; req0 = 1'b1;
        neg();
        chk("mr_rvalid0_after", rvalid0, 1'b0);
        chk("mr_rdata0_clr", rdata0, 16'h0000);
        chk("mr_gnt0_after", gnt0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            cyc();
            neg();
            chk("mr_cnt_clear", gnt1, c == 3);
        end
        cyc();
        req0 = 1'b0; req1 = 1'b0;

        // Back-to-back mixed writes and reads on port 0
        bw[0] = 1'b1; ba[0] = 16'h0050; bd[0] = 16'hAAAA;
        bw[1] = 1'b0; ba[1] = 16'h0050; bd[1] = 16'h0000;
        bw[2] = 1'b1; ba[2] = 16'h0051; bd[2] = 16'h5555;
        bw[3] = 1'b0; ba[3] = 16'h0051; bd[3] = 16'h0000;
        bw[4] = 1'b0; ba[4] = 16'h0010; bd[4] = 16'h0000;
        cyc();
        for (int i = 0; i < 5; i++) begin
            req0 = 1'b1; we0 = bw[i]; addr0 = ba[i]; wdata0 = bd[i];
            neg();
            chk("b2b_gnt0", gnt0, 1'b1);
            if (i == 2) chk("b2b_rd50", rdata0, 16'hAAAA);
            if (i == 4) chk("b2b_rd51", rdata0, 16'h5555);
            cyc();
        end
        req0 = 1'b0;
        neg();
        chk("b2b_rd10", rdata0, 16'hBEEF);
        cyc();
        cyc();
        neg();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
